// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - DEPTH-entry {pc, instr} queue between fetch and decode.
// Optional same-cycle empty-buffer bypass when IFB_BYPASS_EN is defined.
module instr_fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [XLEN-1:0]            push_instr,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [XLEN-1:0]            pop_pc,
  output logic [XLEN-1:0]            pop_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [XLEN-1:0]            last_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] last_pc_q;
  logic            empty, full;
  logic            push_fire, pop_fire, bypass_fire, wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    push_ready = !full;
    pop_valid  = !empty;
    pop_pc     = empty ? '0 : pc_mem[rd_ptr];
    pop_instr  = empty ? '0 : instr_mem[rd_ptr];
`ifdef IFB_BYPASS_EN
    if (empty && !flush) begin
      pop_valid = push_valid;
      pop_pc    = push_pc;
      pop_instr = push_instr;
    end
`endif
  end

  assign push_fire = push_valid && push_ready && !flush;
  assign pop_fire  = pop_valid && pop_ready && !flush;
`ifdef IFB_BYPASS_EN
  // A word passed straight through to decode never occupies an entry.
  assign bypass_fire = empty && pop_fire;
`else
  assign bypass_fire = 1'b0;
`endif
  assign wr_en = push_fire && !bypass_fire;
  assign rd_en = pop_fire && !bypass_fire;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop_fire) last_pc_q <= pop_pc;
    end
  end

  assign count   = count_q;
  assign last_pc = last_pc_q;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - directed and randomized checks of instr_fetch_buffer against a queue model.
module tb_instr_fetch_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, flush, push_valid, push_ready, pop_valid, pop_ready;
  logic [XLEN-1:0] push_pc, push_instr, pop_pc, pop_instr, last_pc;
  logic [2:0]      count;

  int errs = 0;
  int checks = 0;

  logic [63:0]     mq[$];
  logic [XLEN-1:0] m_last;
  bit              m_known = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc), .push_instr(push_instr),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_pc(pop_pc), .pop_instr(pop_instr),
    .count(count), .last_pc(last_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 0; flush = 0; push_valid = 0; pop_ready = 0;
    #1;
  endtask

  // One clock: drive, compare combinational outputs against the model mid-cycle, then advance the model.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic [31:0] pin,
                      input logic pr, input logic fl, input logic rs, output bit acc);
    int n;
    logic e_pr, e_pv, byp;
    logic [31:0] e_pc, e_in;
    reset = rs; flush = fl; push_valid = pv; push_pc = ppc; push_instr = pin; pop_ready = pr;
    @(negedge clk);
    n    = mq.size();
    e_pr = (n < DEPTH);
    byp  = BYP && (n == 0) && !fl;
    e_pv = (n > 0) ? 1'b1 : (byp ? pv : 1'b0);
    e_pc = (n > 0) ? mq[0][63:32] : (byp ? ppc : 32'h0);
    e_in = (n > 0) ? mq[0][31:0]  : (byp ? pin : 32'h0);
    if (m_known) begin
      chk("count", 32'(count), 32'(n));
      chk("push_ready", 32'(push_ready), 32'(e_pr));
      chk("pop_valid", 32'(pop_valid), 32'(e_pv));
      chk("pop_pc", pop_pc, e_pc);
      chk("pop_instr", pop_instr, e_in);
      chk("last_pc", last_pc, m_last);
    end
    acc = 1'b0;
    @(posedge clk);
    if (rs) begin
      mq.delete(); m_last = '0; m_known = 1'b1;
    end else if (fl) begin
      mq.delete();
    end else if (e_pv && pr && n == 0) begin
      m_last = ppc; acc = 1'b1;
    end else begin
      if (e_pv && pr) begin
        m_last = mq[0][63:32];
        void'(mq.pop_front());
      end
      if (pv && e_pr) begin
        mq.push_back({ppc, pin});
        acc = 1'b1;
      end
    end
    #1;
  endtask

  logic [31:0] instrs [6];
  bit          acc;
  logic [31:0] npc, ninstr;
  int          pops_seen;

  initial begin
    instrs[0] = 32'h00000013; instrs[1] = 32'h00100093; instrs[2] = 32'h00200113;
    instrs[3] = 32'h00300193; instrs[4] = 32'h00400213; instrs[5] = 32'h00500293;
    push_pc = '0; push_instr = '0;

    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    idle();
    chk("rst_count", 32'(count), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_pop_pc", pop_pc, 0);
    chk("rst_last_pc", last_pc, 0);

    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), instrs[i], 0, 0, 0, acc);
    idle();
    chk("full_count", 32'(count), 4);
    chk("full_push_ready", 32'(push_ready), 0);
    chk("full_pop_pc", pop_pc, 0);
    step(1, 32'h10, instrs[4], 0, 0, 0, acc);
    chk("fifth_rejected", 32'(acc), 0);
    idle();
    chk("fifth_count", 32'(count), 4);

    // Drain and refill across pointer wrap; the upstream word is held until accepted.
    npc = 32'h10;
    pops_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, npc, {npc[7:0], 24'h000013}, 1, 0, 0, acc);
      if (acc) npc = npc + 4;
      chk("wrap_last_pc", last_pc, 32'(4 * i));
    end
    idle();
    chk("wrap_count", 32'(count), 3);
    chk("wrap_head", pop_pc, 32'h18);

    step(1, npc, 32'h13, 1, 1, 0, acc);
    idle();
    chk("flush_count", 32'(count), 0);
    chk("flush_pop_valid", 32'(pop_valid), 0);
    chk("flush_push_ready", 32'(push_ready), 1);
    chk("flush_last_pc", last_pc, 32'h14);

    step(1, 32'h40, 32'h00A00513, 1, 0, 0, acc);
    idle();
    if (BYP) begin
      chk("byp_count", 32'(count), 0);
      chk("byp_last_pc", last_pc, 32'h40);
    end else begin
      chk("nobyp_count", 32'(count), 1);
      chk("nobyp_pop_valid", 32'(pop_valid), 1);
      chk("nobyp_pop_instr", pop_instr, 32'h00A00513);
      step(0, 0, 0, 1, 0, 0, acc);
      idle();
      chk("nobyp_last_pc", last_pc, 32'h40);
    end

    step(1, 32'h80, 32'h13, 0, 0, 0, acc);
    step(1, 32'h84, 32'h13, 0, 0, 0, acc);
    idle();
    chk("pre_rst_count", 32'(count), 2);
    step(0, 0, 0, 1, 0, 1, acc);
    idle();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_last_pc", last_pc, 0);
    chk("mid_rst_push_ready", 32'(push_ready), 1);

    npc = 32'h1000;
    ninstr = $urandom;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), npc, ninstr, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0), acc);
      if (acc) begin
        npc = npc + 4;
        ninstr = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
